// File: rtl/timer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : timer_pkg
// Description : Shared types and elaboration helpers for the timer bank.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package timer_pkg;

  // Per-channel FSM states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of clock cycles per count unit
  function automatic int calc_ticks(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler register width; clamped to 1 so the vector is always legal
  function automatic int presc_width(input int ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : timer_channel
// Description : One down-counting timer channel: prescaler, count, period,
//               one-shot/periodic mode, start-edge detector, pending flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int TICKS = 10,
  parameter int CNT_W = 16,
  parameter int PW    = presc_width(TICKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_periodic,
  input  logic             i_enable,
  input  logic             i_irq_ack,
  input  logic [CNT_W-1:0] i_load_value,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done,
  output logic             o_irq_pulse,
  output logic             o_irq_pending
);

  localparam logic [PW-1:0]    c_PRESC_MAX = PW'(TICKS - 1);
  localparam logic [PW-1:0]    c_PRESC_ONE = PW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic             r_start_d;
  logic             r_mode;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic             r_done;
  logic             r_irq_pulse;
  logic             r_irq_pending;

  logic             w_start_edge;
  logic             w_load_nz;

  // History resets to 0, so a start held high through reset release is an edge
  assign w_start_edge = i_start & ~r_start_d;
  assign w_load_nz    = (i_load_value != '0);

  // Channel FSM with priority stop > start edge > expiry; outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_start_d     <= 1'b0;
      r_mode        <= 1'b0;
      r_presc       <= '0;
      r_count       <= '0;
      r_period      <= '0;
      r_done        <= 1'b1;
      r_irq_pulse   <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_start_d   <= i_start;
      r_irq_pulse <= 1'b0;
      // Ack clears first so a same-cycle expiry below wins
      if (i_irq_ack) begin
        r_irq_pending <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_done <= 1'b1;
          // Stop alongside the edge keeps us idle; the edge is still consumed
          if (w_start_edge && !i_stop && w_load_nz) begin
            r_state  <= RUN;
            r_period <= i_load_value;
            r_count  <= i_load_value;
            r_mode   <= i_periodic;
            r_presc  <= '0;
            r_done   <= 1'b0;
          end
        end

        RUN: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_done  <= 1'b1;
          end else if (w_start_edge) begin
            if (w_load_nz) begin
              r_period <= i_load_value;
              r_count  <= i_load_value;
              r_mode   <= i_periodic;
              r_presc  <= '0;
            end else begin
              // A zero reload cannot run, so the channel falls back to idle
              r_state <= IDLE;
              r_count <= '0;
              r_presc <= '0;
              r_done  <= 1'b1;
            end
          end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            if (r_count == c_CNT_ONE) begin
              r_irq_pending <= 1'b1;
              r_irq_pulse   <= i_enable;
              if (r_mode) begin
                r_count <= r_period;
              end else begin
                r_count <= '0;
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end else if (r_count != '0) begin
              r_count <= r_count - c_CNT_ONE;
            end
          end else begin
            r_presc <= r_presc + c_PRESC_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign o_count       = r_count;
  assign o_done        = r_done;
  assign o_irq_pulse   = r_irq_pulse;
  assign o_irq_pending = r_irq_pending;

endmodule
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : timer_bank
// Description : NUM_CH independent down-counting timers with an aggregated,
//               registered interrupt output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module timer_bank
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       i_enable,
  input  logic [NUM_CH-1:0]       irq_ack,
  input  logic [NUM_CH*CNT_W-1:0] load_value,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       irq_pulse,
  output logic [NUM_CH-1:0]       irq_pending,
  output logic                    irq
);

  localparam int c_TICKS = calc_ticks(CLK_FREQ_HZ, TICK_HZ);
  localparam int c_PW    = presc_width(c_TICKS);

  logic r_irq;

  generate
    if (c_TICKS < 2) begin : g_bad_ticks
      $error("timer_bank: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("timer_bank: NUM_CH must be in 1..16");
    end
  endgenerate

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      timer_channel #(
        .TICKS (c_TICKS),
        .CNT_W (CNT_W),
        .PW    (c_PW)
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start[k]),
        .i_stop        (stop[k]),
        .i_periodic    (periodic[k]),
        .i_enable      (i_enable[k]),
        .i_irq_ack     (irq_ack[k]),
        .i_load_value  (load_value[k*CNT_W +: CNT_W]),
        .o_count       (count[k*CNT_W +: CNT_W]),
        .o_done        (done[k]),
        .o_irq_pulse   (irq_pulse[k]),
        .o_irq_pending (irq_pending[k])
      );
    end
  endgenerate

  // Aggregate interrupt, registered one cycle behind the pending flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(irq_pending & i_enable);
    end
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_timer_bank
// Description : Self-checking bench for timer_bank (TICKS = 10, 4 channels).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int TICKS  = 10;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH-1:0]       i_enable;
  logic [NUM_CH-1:0]       irq_ack;
  logic [NUM_CH*CNT_W-1:0] load_value;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       irq_pulse;
  logic [NUM_CH-1:0]       irq_pending;
  logic                    irq;

  timer_bank #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .i_enable    (i_enable),
    .irq_ack     (irq_ack),
    .load_value  (load_value),
    .count       (count),
    .done        (done),
    .irq_pulse   (irq_pulse),
    .irq_pending (irq_pending),
    .irq         (irq)
  );

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value equals the number of rising edges seen so far
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_load(input int ch, input int val);
    load_value[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Start edge on channel ch; records the sampling edge in e0
  task automatic kick(input int ch);
    start[ch] = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  task automatic ack(input int ch);
    irq_ack[ch] = 1'b1;
    @(negedge clk);
    irq_ack[ch] = 1'b0;
  endtask

  // Scoreboard: every observed pulse must match a queued expectation
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (irq_pulse[c]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].ch == c) idx = i;
          if (idx < 0) begin
            check($sformatf("unexpected_pulse_ch%0d", c), 32'd1, 32'd0);
          end else begin
            check($sformatf("pulse_cycle_ch%0d", c), cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    start      = '0;
    stop       = '0;
    periodic   = '0;
    i_enable   = '1;
    irq_ack    = '0;
    load_value = '0;
    e0         = 0;

    repeat (2) @(negedge clk);
    check("reset_done", done, 4'hF);
    check("reset_count", count, 0);
    check("reset_pending", irq_pending, 0);
    check("reset_irq", irq, 0);
    rst = 1'b0;
    @(negedge clk);

    // One-shot, ch0, load 3
    set_load(0, 3);
    kick(0);
    sb.push_back('{0, e0 + 3*TICKS});
    check("s1_done_low", done[0], 0);
    check("s1_count_load", cnt_of(0), 3);
    wait_cyc(e0 + 3*TICKS - 1);
    check("s1_count_last", cnt_of(0), 1);
    check("s1_done_before", done[0], 0);
    wait_cyc(e0 + 3*TICKS);
    check("s1_done_high", done[0], 1);
    check("s1_count_zero", cnt_of(0), 0);
    check("s1_pending", irq_pending[0], 1);
    wait_cyc(e0 + 3*TICKS + 1);
    check("s1_irq", irq, 1);
    ack(0);
    check("s1_pending_cleared", irq_pending[0], 0);
    @(negedge clk);
    check("s1_irq_cleared", irq, 0);

    // Periodic, ch1, load 2
    set_load(1, 2);
    periodic[1] = 1'b1;
    kick(1);
    periodic[1] = 1'b0;
    sb.push_back('{1, e0 + 20});
    sb.push_back('{1, e0 + 40});
    sb.push_back('{1, e0 + 60});
    wait_cyc(e0 + 20);
    check("s2_reload", cnt_of(1), 2);
    check("s2_done_low", done[1], 0);
    wait_cyc(e0 + 41);
    check("s2_count_mid", cnt_of(1), 2);
    wait_cyc(e0 + 60);
    check("s2_done_low_late", done[1], 0);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    check("s2_stop_done", done[1], 1);
    check("s2_stop_count", cnt_of(1), 0);
    ack(1);

    // Stop mid-run, ch0
    set_load(0, 3);
    kick(0);
    wait_cyc(e0 + 14);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    check("s3_done", done[0], 1);
    check("s3_count", cnt_of(0), 0);
    wait_cyc(e0 + 100);
    check("s3_no_pending", irq_pending[0], 0);

    // Restart, ch2
    set_load(2, 3);
    kick(2);
    wait_cyc(e0 + 24);
    start[2] = 1'b1;
    sb.push_back('{2, e0 + 55});
    @(negedge clk);
    start[2] = 1'b0;
    check("s4_count_restart", cnt_of(2), 3);
    wait_cyc(e0 + 60);
    check("s4_done", done[2], 1);
    ack(2);

    // Zero load, then start held high, ch3
    set_load(3, 0);
    kick(3);
    repeat (3) @(negedge clk);
    check("s5_zero_done", done[3], 1);
    check("s5_zero_pending", irq_pending[3], 0);
    set_load(3, 2);
    start[3] = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{3, e0 + 20});
    @(negedge clk);
    check("s5_hold_run", done[3], 0);
    wait_cyc(e0 + 49);
    check("s5_hold_once", done[3], 1);
    start[3] = 1'b0;
    @(negedge clk);
    ack(3);

    // Interrupt disabled on ch3, then enabled; ack racing expiry
    i_enable[3] = 1'b0;
    set_load(3, 2);
    periodic[3] = 1'b1;
    kick(3);
    periodic[3] = 1'b0;
    wait_cyc(e0 + 20);
    check("s6_pending_gated", irq_pending[3], 1);
    wait_cyc(e0 + 21);
    check("s6_irq_gated", irq, 0);
    i_enable[3] = 1'b1;
    sb.push_back('{3, e0 + 40});
    @(negedge clk);
    check("s6_irq_enabled", irq, 1);
    wait_cyc(e0 + 39);
    irq_ack[3] = 1'b1;
    @(negedge clk);
    irq_ack[3] = 1'b0;
    check("s6_set_wins", irq_pending[3], 1);
    stop[3] = 1'b1;
    @(negedge clk);
    stop[3] = 1'b0;
    ack(3);
    check("s6_pending_acked", irq_pending[3], 0);

    // Asynchronous reset mid-run
    set_load(0, 3);
    set_load(1, 1);
    periodic[0] = 1'b1;
    start[0] = 1'b1;
    start[1] = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{1, e0 + 10});
    @(negedge clk);
    start = '0;
    periodic = '0;
    wait_cyc(e0 + 15);
    check("s7_pending_before", irq_pending[1], 1);
    #2 rst = 1'b1;
    #1;
    check("s7_rst_done", done, 4'hF);
    check("s7_rst_count", count, 0);
    check("s7_rst_pending", irq_pending, 0);
    check("s7_rst_pulse", irq_pulse, 0);
    check("s7_rst_irq", irq, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("s7_idle_after", done, 4'hF);

    check("sb_missing_pulses", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_bank.md
# timer_bank

Multi-channel down-counting timer bank that generalises the single millisecond timer. It has NUM_CH independent channels. Each channel has its own exact prescaler, a one-shot or periodic mode, a stop control and a sticky interrupt-pending flag with acknowledge. The bank sits on the CPU peripheral side: software-facing registers drive start, stop and load values, and the aggregated `irq` feeds the CPU interrupt input.

## Interface
- `CLK_FREQ_HZ`, 27000000, input clock frequency.
- `TICK_HZ`, 1000, count unit rate.
  - TICKS = CLK_FREQ_HZ/TICK_HZ.
  - Elaboration fails if TICKS < 2.
- `NUM_CH`, 4, number of channels (1..16).
- `CNT_W`, 16, count width in units.
- `clk` in 1, system clock.
- `rst` in 1, asynchronous, active-high reset.
- `start` in NUM_CH, per-channel start; rising-edge detected internally.
- `stop` in NUM_CH, per-channel stop, level-sampled.
- `periodic` in NUM_CH, 1 = auto-reload mode; sampled at start.
- `i_enable` in NUM_CH, per-channel interrupt enable.
- `irq_ack` in NUM_CH, clears the pending flag; level-sampled.
- `load_value` in NUM_CH*CNT_W, channel k at bits [k*CNT_W +: CNT_W].
- `count` out NUM_CH*CNT_W, remaining units per channel.
- `done` out NUM_CH, 1 when the channel is idle.
- `irq_pulse` out NUM_CH, 1-cycle pulse on each expiry, gated by `i_enable`.
- `irq_pending` out NUM_CH, sticky expiry flag (ungated).
- `irq` out 1, OR over (irq_pending & i_enable).

## Operation
- Per-channel FSM has two states, IDLE and RUN.
- In IDLE:
  - `done`=1.
  - Start edge with load_value != 0: latch `period`←load_value, `count`←load_value, mode←periodic[k], prescaler←0, go to RUN.
  - Start edge with load_value == 0: no state change, no interrupt.
- In RUN:
  - Prescaler increments each cycle and wraps at TICKS-1.
  - At wrap, `count` decrements by 1.
  - Expiry is a wrap with count == 1.
- On expiry:
  - One-shot: count←0, go to IDLE.
  - Periodic: count←period, prescaler←0, stay in RUN.
  - Both modes: set irq_pending; assert irq_pulse if i_enable.
- Start edge in RUN: restart with a fresh latch of load_value and periodic, prescaler←0. The pending flag is unaffected.
- Stop in RUN: go to IDLE, count←0, no expiry and no interrupt. Stop in IDLE is ignored.
- Priority within a channel, same cycle: stop > start edge > expiry.
- Stop asserted together with the start edge leaves the channel in IDLE. The edge is still consumed, so holding start high does not re-trigger.
- irq_pending:
  - Set on expiry, cleared by irq_ack.
  - Expiry and irq_ack in the same cycle leaves it set (set wins).
- Channels are fully independent. Simultaneous expiries each pulse on their own bit.

## Timing
- All outputs are registered.
- Reset values:
  - done = all 1.
  - count = 0.
  - irq_pulse = 0, irq_pending = 0, irq = 0.
  - Start-edge history = 0; a start held high through reset release counts as an edge.
- Start edge sampled at edge E0:
  - `done` falls at E0+1.
  - `count` = N at E0+1.
  - Expiry registers at edge E0 + N*TICKS.
  - done rises and irq_pulse is high during the cycle after that edge.
- Periodic mode: expiries every N*TICKS cycles exactly, no drift.
- irq follows irq_pending & i_enable with a 1-cycle register delay.
- Changing load_value during RUN has no effect until the next start edge.
- Asynchronous reset mid-count returns the channel to IDLE immediately. No interrupt is generated.
- Prescaler width is $clog2(TICKS). Count arithmetic is CNT_W-bit unsigned and never underflows: the decrement occurs only when count ≥ 1.

## Structure
- Shared package `timer_pkg` holds:
  - state enum {IDLE, RUN};
  - the TICKS computation function;
  - the prescaler-width function.
- Sub-module `timer_channel` holds:
  - one channel's FSM, prescaler, count, period, mode and edge detector;
  - the pending flag.
- `timer_bank` instantiates NUM_CH channels via generate, slices the buses and ORs `irq`.

## Test plan
Parameters for all scenarios: CLK_FREQ_HZ=1000, TICK_HZ=100 (TICKS=10), NUM_CH=4, CNT_W=16.
- One-shot, ch0, load 3: start at E0 -> done low at E0+1; irq_pulse[0] one cycle after edge E0+30; done high; irq_pending[0]=1 until irq_ack.
- Periodic, ch1, load 2, i_enable=1 -> irq_pulse[1] at E0+20, +40, +60; done stays 0; count reloads to 2 after each expiry.
- Stop at E0+15 on ch0 with load 3 -> done=1, count=0, no irq_pulse through E0+100.
- Restart: start edge at E0+25 on ch2 with load 3 -> expiry at E0+55, not E0+30.
- Start with load_value 0 -> done stays 1, no pulse. Start held high 50 cycles -> exactly one run.
- i_enable=0 on ch3 with expiry -> irq_pulse[3]=0, irq_pending[3]=1, irq=0. Raising i_enable then gives irq=1 the next cycle. irq_ack in the same cycle as a second expiry keeps pending=1.
- Async rst mid-run -> all outputs at reset values before the next clk edge.
